// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and flag bundle for the sequential-divide ALU.
// No logic of its own; sized helpers derive widths from the ALU WIDTH parameter.
package alu_pkg;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h08;
  localparam logic [7:0] OP_XOR = 8'h10;
  localparam logic [7:0] OP_SHL = 8'h20;
  localparam logic [7:0] OP_SHR = 8'h40;
  localparam logic [7:0] OP_DIV = 8'h80;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DIV  = 1'b1;

  typedef struct packed {
    logic carry;
    logic div_zero;
    logic err;
  } flags_t;

  // Shift amount is taken from the low clog2(WIDTH) bits of operand b.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_div_core.sv
// Restoring divider: one quotient bit per cycle, WIDTH steps after start; done marks the final step.
// quotient/remainder are the combinational result of the current step, valid only while done=1; start ignored while busy.
module alu_div_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign r_shift = {r_q, q_q[WIDTH-1]};
  assign diff    = r_shift - {1'b0, d_q};
  assign fits    = ~diff[WIDTH];
  assign q_next  = {q_q[WIDTH-2:0], fits};
  assign r_next  = fits ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];

  assign done      = busy && (cnt == CW'(WIDTH - 1));
  assign quotient  = q_next;
  assign remainder = r_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      r_q  <= '0;
      q_q  <= '0;
      d_q  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      r_q  <= '0;
      q_q  <= dividend;
      d_q  <= divisor;
    end else if (busy) begin
      r_q <= r_next;
      q_q <= q_next;
      if (done) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_div.sv
// Opcode ALU with registered results: latency 1 for single-cycle ops, WIDTH+1 for DIV with nonzero divisor.
// Backpressure: in_ready=0 while a division is iterating; one operation in flight, back-to-back accepts in IDLE.
module alu_seq_div
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OPCODE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  output logic [WIDTH-1:0]    z,
  output logic [WIDTH-1:0]    rem,
  output logic                carry,
  output logic                div_zero,
  output logic                err
);

  localparam int SW = shamt_w(WIDTH);

  logic [0:0]       state;
  logic             accept;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_z;
  logic [WIDTH-1:0] sc_rem;
  flags_t           sc_flags;
  flags_t           flags_q;

  assign in_ready  = (state == ST_IDLE) && !div_busy;
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (opcode == OPCODE_W'(OP_DIV)) && (b != '0);
  assign sum       = {1'b0, a} + {1'b0, b};

  alu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .remainder(div_r)
  );

  // DIV only reaches this path with b==0; the nonzero case goes to the divider.
  always_comb begin
    sc_z     = '0;
    sc_rem   = '0;
    sc_flags = '0;
    case (opcode)
      OPCODE_W'(OP_ADD): begin
        sc_z           = sum[WIDTH-1:0];
        sc_flags.carry = sum[WIDTH];
      end
      OPCODE_W'(OP_SUB): begin
        sc_z           = a - b;
        sc_flags.carry = (a < b);
      end
      OPCODE_W'(OP_AND): sc_z = a & b;
      OPCODE_W'(OP_OR):  sc_z = a | b;
      OPCODE_W'(OP_XOR): sc_z = a ^ b;
      OPCODE_W'(OP_SHL): sc_z = a << b[SW-1:0];
      OPCODE_W'(OP_SHR): sc_z = a >> b[SW-1:0];
      OPCODE_W'(OP_DIV): begin
        sc_z              = '1;
        sc_rem            = a;
        sc_flags.div_zero = 1'b1;
      end
      default: sc_flags.err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      z         <= '0;
      rem       <= '0;
      flags_q   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (div_start) begin
            state <= ST_DIV;
          end else if (accept) begin
            out_valid <= 1'b1;
            z         <= sc_z;
            rem       <= sc_rem;
            flags_q   <= sc_flags;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            z         <= div_q;
            rem       <= div_r;
            flags_q   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign carry    = flags_q.carry;
  assign div_zero = flags_q.div_zero;
  assign err      = flags_q.err;

endmodule
